cnn_pool_stream: RTL and testbench
==================================

CNN_POOL_STREAM -- requirements
Module: cnn_pool_stream

Interface
REQ-001 Parameter DATA_W, default 32: signed pixel width, input and output.
REQ-002 Parameter IMG_W, default 24: input frame width in pixels; even, >=2.
REQ-003 Parameter IMG_H, default 24: input frame height in rows; even, >=2.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  frame start request; sampled only in IDLE.
REQ-007 in_data  input  DATA_W  signed pixel, raster order (row-major, column 0 first).
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 out_data  output  DATA_W  signed pooled pixel.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 done  output  1  one-cycle pulse at frame completion.

Function
REQ-014 2x2 max-pool, stride 2, producing (IMG_W/2)x(IMG_H/2) outputs in raster order.
REQ-015 States IDLE, RUN, DRAIN, DONE; IDLE->RUN on enable=1; RUN->DRAIN when the frame's last pixel (row IMG_H-1, col IMG_W-1) is accepted; DRAIN->DONE when the last output handshakes; DONE->IDLE after one cycle.
REQ-016 Input accept = in_valid && in_ready; in_ready = 1 only in RUN and when (!out_valid || out_ready).
REQ-017 Column counter 0..IMG_W-1 and row counter 0..IMG_H-1 advance only on input accept; column wraps to 0 and increments row.
REQ-018 Even row: even column stores pixel in hold register; odd column writes max(hold, pixel) to line buffer entry col/2 (IMG_W/2 entries).
REQ-019 Odd row: even column stores pixel in hold register; odd column loads out_data = max(linebuf[col/2], hold, pixel) and sets out_valid.
REQ-020 Latency: out_valid asserts the cycle after acceptance of the completing pixel.
REQ-021 out_valid and out_data hold stable until out_valid && out_ready; out_valid clears on handshake unless a new result loads the same cycle (then stays 1 with new data).
REQ-022 Comparisons are signed; equal values select either operand (result identical).
REQ-023 enable while not IDLE is ignored; in_valid outside RUN is ignored (in_ready=0).
REQ-024 done = 1 only in DONE; one cycle exactly.

Reset
REQ-025 rst=0 asynchronously forces IDLE, counters 0, hold 0, out_valid 0, out_data 0, in_ready 0, done 0.
REQ-026 Line buffer contents need no reset; never read before written within a frame.
REQ-027 Reset mid-frame discards the partial frame; after release the next enable starts a fresh frame at row 0, col 0.

Configuration
REQ-028 Macro POOL_RELU_EN defined: each input pixel is clamped to max(pixel,0) before pooling, so out_data >= 0.
REQ-029 POOL_RELU_EN undefined: raw signed pixels pooled; negative out_data possible.

Verification
REQ-030 IMG_W=4, IMG_H=4, pixels 0..15, out_ready=1 -> outputs 5,7,13,15 in order, then done pulse once.
REQ-031 Same size, all pixels -3 -> outputs 0,0,0,0 with POOL_RELU_EN; -3,-3,-3,-3 without.
REQ-032 Hold out_ready=0 for 5 cycles while out_valid=1 -> in_ready=0, out_data stable, no input lost; resumes exactly on out_ready=1.
REQ-033 Pulse rst low mid-frame after 6 pixels accepted -> all outputs at reset values; new frame of 0..15 yields 5,7,13,15.
REQ-034 Assert enable continuously during RUN and DRAIN -> no restart; one done per frame; next frame starts only after return to IDLE.
REQ-035 Defaults (24x24), random signed pixels with random in_valid/out_ready gaps -> 144 outputs matching a reference model, done once.

Source files
------------

// File: rtl/cnn_pool_stream.sv
// Streaming 2x2/stride-2 signed max-pool over an IMG_W x IMG_H raster frame.
// Optional build macro POOL_RELU_EN clamps every input pixel to >= 0 before pooling.
module cnn_pool_stream #(
    parameter int DATA_W = 32,
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     done
);
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LW = CW - 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                     state_q;
    logic [CW-1:0]              col_q, col_d;
    logic [RW-1:0]              row_q, row_d;
    logic signed [DATA_W-1:0]   hold_q;
    logic signed [DATA_W-1:0]   out_data_q, out_data_d;
    logic                       out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0]   linebuf [IMG_W/2];

    logic signed [DATA_W-1:0]   px, lb_rd, pair_max, quad_max;
    logic [LW-1:0]              lb_idx;
    logic                       accept, last_col, last_row, emit;

    function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign last_col  = (col_q == CW'(IMG_W - 1));
    assign last_row  = (row_q == RW'(IMG_H - 1));
    assign lb_idx    = col_q[CW-1:1];
    assign lb_rd     = linebuf[lb_idx];
    assign pair_max  = smax(hold_q, px);
    assign quad_max  = smax(lb_rd, pair_max);
    // A pooled result completes on the odd column of an odd row.
    assign emit      = accept && col_q[0] && row_q[0];
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign done      = (state_q == DONE);

    always_comb begin
`ifdef POOL_RELU_EN
        px = in_data[DATA_W-1] ? '0 : in_data;
`else
        px = in_data;
`endif
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (emit) begin
            out_data_d  = quad_max;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            if (accept && !col_q[0]) hold_q <= px;
            case (state_q)
                IDLE: if (enable) begin
                    state_q <= RUN;
                    col_q   <= '0;
                    row_q   <= '0;
                end
                RUN:   if (accept && last_col && last_row) state_q <= DRAIN;
                DRAIN: if (out_valid_q && out_ready) state_q <= DONE;
                DONE:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line buffer holds the even-row pair maxima; written before any odd-row read.
    always_ff @(posedge clk) begin
        if (accept && col_q[0] && !row_q[0]) linebuf[lb_idx] <= pair_max;
    end
endmodule

// File: tb/tb_cnn_pool_stream.sv
// Directed bench: 4x4 frames (pattern, negative, backpressure, mid-frame reset,
// held enable) plus one 24x24 frame with random pixels and handshake gaps.
module tb_cnn_pool_stream;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                 en4 = 0, iv4 = 0, or4 = 1;
    logic                 ir4, ov4, dn4;
    logic signed [DW-1:0] id4 = '0, od4;
    logic                 en24 = 0, iv24 = 0, or24 = 1;
    logic                 ir24, ov24, dn24;
    logic signed [DW-1:0] id24 = '0, od24;

    cnn_pool_stream #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .rst(rst), .enable(en4), .in_data(id4), .in_valid(iv4), .in_ready(ir4),
        .out_data(od4), .out_valid(ov4), .out_ready(or4), .done(dn4));

    cnn_pool_stream #(.DATA_W(DW), .IMG_W(24), .IMG_H(24)) dut24 (
        .clk(clk), .rst(rst), .enable(en24), .in_data(id24), .in_valid(iv24), .in_ready(ir24),
        .out_data(od24), .out_valid(ov24), .out_ready(or24), .done(dn24));

    int total = 0, bad = 0;
    int done4 = 0, done24 = 0, idx24 = 0, last_wait = 0;
    logic signed [DW-1:0] q4[$];
    logic signed [DW-1:0] exp24 [144];
    logic signed [DW-1:0] pix24 [576];
    int e_ramp [4] = '{5, 7, 13, 15};
    bit stop24 = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] v);
`ifdef POOL_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic signed [DW-1:0] mx(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    always @(negedge clk) if (rst) begin
        if (ov4 && or4) q4.push_back(od4);
        if (dn4) done4++;
        if (ov24 && or24) begin
            if (idx24 < 144) chk("pool24", od24, exp24[idx24]);
            idx24++;
        end
        if (dn24) done24++;
    end

    task automatic push4(input logic signed [DW-1:0] v);
        int n = 0;
        id4 = v; iv4 = 1;
        @(negedge clk);
        while (!ir4 && n < 50) begin n++; @(negedge clk); end
        last_wait = n;
        if (!ir4) chk("push4_timeout", 0, 1);
        @(posedge clk); #1;
        iv4 = 0;
    endtask

    task automatic start4();
        en4 = 1;
        @(posedge clk); #1;
        en4 = 0;
    endtask

    task automatic wait_done4(input int prev);
        int n = 0;
        while (done4 == prev && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk("done_once", done4, prev + 1);
    endtask

    task automatic check_outs4(input string tag, input bit neg);
        chk({tag, "_count"}, q4.size(), 4);
        for (int k = 0; k < 4 && k < q4.size(); k++)
            chk(tag, q4[k], neg ? relu(-3) : e_ramp[k]);
    endtask

    task automatic frame4(input string tag, input bit neg, input bit lat);
        int d0 = done4;
        q4.delete();
        start4();
        for (int i = 0; i < 16; i++) begin
            push4(neg ? -3 : i);
            if (lat && ((i / 4) % 2 == 1) && (i % 2 == 1)) chk("latency_valid", ov4, 1);
        end
        wait_done4(d0);
        check_outs4(tag, neg);
        chk({tag, "_idle_ready"}, ir4, 0);
    endtask

    initial begin
        int d0, n;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", ov4, 0);
        chk("rst_out_data", od4, 0);
        chk("rst_in_ready", ir4, 0);
        chk("rst_done", dn4, 0);
        rst = 1;
        repeat (2) @(negedge clk);

        // in_valid outside RUN must be ignored
        iv4 = 1; id4 = 99;
        @(negedge clk);
        chk("idle_in_ready", ir4, 0);
        iv4 = 0;

        frame4("ramp", 0, 1);
        frame4("neg3", 1, 0);

        // Backpressure: stall with a result pending, then resume.
        or4 = 0; q4.delete(); d0 = done4;
        start4();
        for (int i = 0; i < 6; i++) push4(i);
        chk("bp_valid", ov4, 1);
        id4 = 6; iv4 = 1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", ir4, 0);
            chk("bp_data", od4, 5);
        end
        @(posedge clk); #1;
        or4 = 1;
        push4(6);
        chk("bp_resume_wait", last_wait, 0);
        for (int i = 7; i < 16; i++) push4(i);
        wait_done4(d0);
        check_outs4("bp", 0);

        // Mid-frame reset after 6 pixels.
        start4();
        for (int i = 0; i < 6; i++) push4(i);
        @(negedge clk);
        rst = 0;
        #1;
        chk("mrst_out_valid", ov4, 0);
        chk("mrst_out_data", od4, 0);
        chk("mrst_in_ready", ir4, 0);
        chk("mrst_done", dn4, 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        frame4("after_rst", 0, 0);

        // Enable held through RUN and DRAIN.
        q4.delete(); d0 = done4;
        en4 = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) push4(i);
        n = 0;
        while (!dn4 && n < 100) begin @(negedge clk); n++; end
        en4 = 0;
        repeat (4) @(negedge clk);
        chk("hold_en_done", done4, d0 + 1);
        chk("hold_en_idle", ir4, 0);
        check_outs4("hold_en", 0);

        // 24x24 random frame with gaps on both sides.
        for (int i = 0; i < 576; i++) pix24[i] = $signed($urandom_range(0, 2000)) - 1000;
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 12; c++)
                exp24[r*12+c] = mx(mx(relu(pix24[(2*r)*24 + 2*c]), relu(pix24[(2*r)*24 + 2*c+1])),
                                   mx(relu(pix24[(2*r+1)*24 + 2*c]), relu(pix24[(2*r+1)*24 + 2*c+1])));
        fork
            while (!stop24) begin
                @(posedge clk); #1;
                or24 = ($urandom_range(0, 3) != 0);
            end
        join_none
        en24 = 1;
        @(posedge clk); #1;
        en24 = 0;
        for (int i = 0; i < 576; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            id24 = pix24[i]; iv24 = 1;
            n = 0;
            @(negedge clk);
            while (!ir24 && n < 50) begin n++; @(negedge clk); end
            if (!ir24) chk("push24_timeout", 0, 1);
            @(posedge clk); #1;
            iv24 = 0;
        end
        n = 0;
        while (done24 == 0 && n < 200) begin @(negedge clk); n++; end
        stop24 = 1;
        repeat (4) @(negedge clk);
        chk("pool24_count", idx24, 144);
        chk("pool24_done", done24, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
